// File: rtl/or32_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module  : or32_bus_pkg
// Brief   : Shared widths, state encoding and request bundle for the or32
//           two-master bus arbiter.
// Revision: 1.0 - initial release
// ============================================================================
package or32_bus_pkg;

    localparam int unsigned c_ADDR_W = 32;
    localparam int unsigned c_DATA_W = 32;
    localparam int unsigned c_BE_W   = 4;

    localparam logic [c_DATA_W-1:0] c_ERR_DATA = 32'hDEADBEEF;

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_WAIT = 1'b1;

    typedef struct packed {
        logic [c_ADDR_W-1:0] addr;
        logic [c_DATA_W-1:0] dat_w;
        logic [c_BE_W-1:0]   we;
    } bus_req_t;

    function automatic bus_req_t pick_req(input logic sel, input bus_req_t req0,
                                          input bus_req_t req1);
        return sel ? req1 : req0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/or32_bus_timeout.sv
`default_nettype none
// ============================================================================
// Module  : or32_bus_timeout
// Brief   : Counts enabled cycles without a clear and pulses o_expire on the
//           TIMEOUT_CYCLES-th one. TIMEOUT_CYCLES = 0 disables the watchdog.
// Revision: 1.0 - initial release
// ============================================================================
module or32_bus_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    input  logic i_clr,
    output logic o_expire
);

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_disabled
            assign o_expire = 1'b0;
        end else begin : g_enabled
            localparam int unsigned c_CNT_W =
                (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
            localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

            logic [c_CNT_W-1:0] r_count;

            always_ff @(posedge i_clk) begin
                if (i_rst || !i_en || i_clr) begin
                    r_count <= '0;
                end else begin
                    r_count <= r_count + c_CNT_W'(1);
                end
            end

            // Fires during the last idle cycle so completion lands one cycle later.
            assign o_expire = i_en && !i_clr && (r_count == c_LAST);
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/or32_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : or32_bus_arbiter
// Brief   : Shares the or32 memory bus between the core (m0) and a secondary
//           master (m1); one outstanding slave transaction with a watchdog.
// Revision: 1.0 - initial release
// ============================================================================
module or32_bus_arbiter
    import or32_bus_pkg::*;
#(
    parameter int unsigned          PRIO_MODE      = 0,
    parameter int unsigned          TIMEOUT_CYCLES = 1024,
    parameter logic [c_DATA_W-1:0]  ERR_DATA       = c_ERR_DATA
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [c_ADDR_W-1:0] i_m0_addr,
    input  logic [c_DATA_W-1:0] i_m0_dat_w,
    input  logic [c_BE_W-1:0]   i_m0_we,
    input  logic                i_m0_stb,
    output logic [c_DATA_W-1:0] o_m0_dat_r,
    output logic                o_m0_ack,
    input  logic [c_ADDR_W-1:0] i_m1_addr,
    input  logic [c_DATA_W-1:0] i_m1_dat_w,
    input  logic [c_BE_W-1:0]   i_m1_we,
    input  logic                i_m1_stb,
    output logic [c_DATA_W-1:0] o_m1_dat_r,
    output logic                o_m1_ack,
    output logic [c_ADDR_W-1:0] o_s_addr,
    output logic [c_DATA_W-1:0] o_s_dat_w,
    output logic [c_BE_W-1:0]   o_s_we,
    output logic                o_s_stb,
    input  logic [c_DATA_W-1:0] i_s_dat_r,
    input  logic                i_s_ack,
    output logic                o_err,
    output logic                o_grant
);

    logic [0:0]          r_state;
    logic                r_last_grant;
    logic                r_pend0;
    logic                r_pend1;
    logic                w_busy0;
    logic                w_busy1;
    logic                w_stb0;
    logic                w_stb1;
    logic                w_req0;
    logic                w_req1;
    logic                w_winner;
    logic                w_start;
    logic                w_ack;
    logic                w_expire;
    logic                w_done;
    logic [c_DATA_W-1:0] w_rdata;
    bus_req_t            w_bus_m0;
    bus_req_t            w_bus_m1;
    bus_req_t            w_bus_sel;

    // A strobe from a master already queued or being served is dropped.
    assign w_busy0 = (r_state == c_ST_WAIT) && !o_grant;
    assign w_busy1 = (r_state == c_ST_WAIT) &&  o_grant;
    assign w_stb0  = i_m0_stb && !r_pend0 && !w_busy0;
    assign w_stb1  = i_m1_stb && !r_pend1 && !w_busy1;
    assign w_req0  = r_pend0 || w_stb0;
    assign w_req1  = r_pend1 || w_stb1;

    generate
        if (PRIO_MODE == 1) begin : g_fixed_prio
            assign w_winner = !w_req0;
        end else begin : g_round_robin
            assign w_winner = (w_req0 && w_req1) ? !r_last_grant : w_req1;
        end
    endgenerate

    assign w_start   = (r_state == c_ST_IDLE) && (w_req0 || w_req1);
    assign w_ack     = (r_state == c_ST_WAIT) && i_s_ack;
    assign w_done    = w_ack || w_expire;
    assign w_rdata   = w_ack ? i_s_dat_r : ERR_DATA;
    assign w_bus_m0  = {i_m0_addr, i_m0_dat_w, i_m0_we};
    assign w_bus_m1  = {i_m1_addr, i_m1_dat_w, i_m1_we};
    assign w_bus_sel = pick_req(w_winner, w_bus_m0, w_bus_m1);

    or32_bus_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_en     (r_state == c_ST_WAIT),
        .i_clr    (i_s_ack),
        .o_expire (w_expire)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= c_ST_IDLE;
            r_last_grant <= 1'b1;
            r_pend0      <= 1'b0;
            r_pend1      <= 1'b0;
            o_s_addr     <= '0;
            o_s_dat_w    <= '0;
            o_s_we       <= '0;
            o_s_stb      <= 1'b0;
            o_m0_dat_r   <= '0;
            o_m0_ack     <= 1'b0;
            o_m1_dat_r   <= '0;
            o_m1_ack     <= 1'b0;
            o_err        <= 1'b0;
            o_grant      <= 1'b0;
        end else begin
            o_s_stb  <= 1'b0;
            o_m0_ack <= 1'b0;
            o_m1_ack <= 1'b0;
            o_err    <= 1'b0;

            if (w_start && !w_winner) begin
                r_pend0 <= 1'b0;
            end else if (w_stb0) begin
                r_pend0 <= 1'b1;
            end
            if (w_start && w_winner) begin
                r_pend1 <= 1'b0;
            end else if (w_stb1) begin
                r_pend1 <= 1'b1;
            end

            case (r_state)
                c_ST_IDLE: begin
                    if (w_start) begin
                        o_s_addr     <= w_bus_sel.addr;
                        o_s_dat_w    <= w_bus_sel.dat_w;
                        o_s_we       <= w_bus_sel.we;
                        o_s_stb      <= 1'b1;
                        o_grant      <= w_winner;
                        r_last_grant <= w_winner;
                        r_state      <= c_ST_WAIT;
                    end
                end
                c_ST_WAIT: begin
                    if (w_done) begin
                        if (o_grant) begin
                            o_m1_ack   <= 1'b1;
                            o_m1_dat_r <= w_rdata;
                        end else begin
                            o_m0_ack   <= 1'b1;
                            o_m0_dat_r <= w_rdata;
                        end
                        o_err   <= w_expire;
                        o_s_we  <= '0;
                        r_state <= c_ST_IDLE;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_or32_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_or32_bus_arbiter
// Brief   : Directed bench: round-robin instance and fixed-priority instance
//           driven by the same masters and a simple delayed-ack slave.
// Revision: 1.0 - initial release
// ============================================================================
module tb_or32_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] m0_addr = '0, m0_dat_w = '0, m1_addr = '0, m1_dat_w = '0;
    logic [3:0]  m0_we = '0, m1_we = '0;
    logic        m0_stb = 1'b0, m1_stb = 1'b0;
    logic [31:0] s_dat_r = '0;
    logic        s_ack = 1'b0;

    logic [31:0] m0_dat_r, m1_dat_r, s_addr, s_dat_w;
    logic [3:0]  s_we;
    logic        m0_ack, m1_ack, s_stb, err, grant;
    logic [31:0] p_m0_dat_r, p_m1_dat_r, p_s_addr, p_s_dat_w;
    logic [3:0]  p_s_we;
    logic        p_m0_ack, p_m1_ack, p_s_stb, p_err, p_grant;

    logic        s_auto = 1'b1;
    int          s_delay = 1;
    int          s_cnt = -1;
    logic [31:0] s_resp = '0;

    int n_checks = 0;
    int n_pass = 0;
    int q0[$];
    int qp[$];

    always #5 clk = ~clk;

    or32_bus_arbiter #(.PRIO_MODE(0), .TIMEOUT_CYCLES(8)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_m0_addr(m0_addr), .i_m0_dat_w(m0_dat_w), .i_m0_we(m0_we), .i_m0_stb(m0_stb),
        .o_m0_dat_r(m0_dat_r), .o_m0_ack(m0_ack),
        .i_m1_addr(m1_addr), .i_m1_dat_w(m1_dat_w), .i_m1_we(m1_we), .i_m1_stb(m1_stb),
        .o_m1_dat_r(m1_dat_r), .o_m1_ack(m1_ack),
        .o_s_addr(s_addr), .o_s_dat_w(s_dat_w), .o_s_we(s_we), .o_s_stb(s_stb),
        .i_s_dat_r(s_dat_r), .i_s_ack(s_ack), .o_err(err), .o_grant(grant)
    );

    or32_bus_arbiter #(.PRIO_MODE(1), .TIMEOUT_CYCLES(8)) dut_p (
        .i_clk(clk), .i_rst(rst),
        .i_m0_addr(m0_addr), .i_m0_dat_w(m0_dat_w), .i_m0_we(m0_we), .i_m0_stb(m0_stb),
        .o_m0_dat_r(p_m0_dat_r), .o_m0_ack(p_m0_ack),
        .i_m1_addr(m1_addr), .i_m1_dat_w(m1_dat_w), .i_m1_we(m1_we), .i_m1_stb(m1_stb),
        .o_m1_dat_r(p_m1_dat_r), .o_m1_ack(p_m1_ack),
        .o_s_addr(p_s_addr), .o_s_dat_w(p_s_dat_w), .o_s_we(p_s_we), .o_s_stb(p_s_stb),
        .i_s_dat_r(s_dat_r), .i_s_ack(s_ack), .o_err(p_err), .o_grant(p_grant)
    );

    // Slave: acks s_delay cycles after the o_s_stb cycle of the round-robin DUT.
    initial begin : slave
        forever begin
            @(negedge clk);
            if (s_auto) begin
                s_ack = 1'b0;
                if (s_cnt > 0) begin
                    s_cnt--;
                    if (s_cnt == 0) begin
                        s_ack   = 1'b1;
                        s_dat_r = s_resp;
                        s_cnt   = -1;
                    end
                end
                if (s_stb) s_cnt = s_delay;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, act, exp);
    endtask

    task automatic pulse(input bit p0, input bit p1);
        @(negedge clk);
        m0_stb = p0;
        m1_stb = p1;
        @(negedge clk);
        m0_stb = 1'b0;
        m1_stb = 1'b0;
    endtask

    task automatic wait_ack(input bit m, input int budget, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            if (m ? m1_ack : m0_ack) got = 1'b1;
        end
    endtask

    task automatic collect(input int n, input int budget);
        q0.delete();
        qp.delete();
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (m0_ack)   q0.push_back(0);
            if (m1_ack)   q0.push_back(1);
            if (p_m0_ack) qp.push_back(0);
            if (p_m1_ack) qp.push_back(1);
            if (q0.size() >= n && qp.size() >= n) break;
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin : stim
        bit got;
        int early;

        // Reset state
        @(negedge clk);
        check_eq("rst_outs", {s_addr | s_dat_w | m0_dat_r | m1_dat_r},  32'h0);
        check_eq("rst_ctl", {s_we, s_stb, m0_ack, m1_ack, err, grant}, 32'h0);
        rst = 1'b0;

        // Single m0 read: o_m0_ack three cycles after stb
        m0_addr = 32'h0000_0040; m0_we = 4'h0; s_resp = 32'h1234_5678; s_delay = 1;
        pulse(1'b1, 1'b0);
        check_eq("rd_s_stb", s_stb, 1);
        check_eq("rd_s_addr", s_addr, 32'h0000_0040);
        check_eq("rd_grant", grant, 0);
        @(negedge clk);
        check_eq("rd_stb_pulse", s_stb, 0);
        check_eq("rd_ack_early", m0_ack, 0);
        @(negedge clk);
        check_eq("rd_ack", m0_ack, 1);
        check_eq("rd_data", m0_dat_r, 32'h1234_5678);
        check_eq("rd_m1_ack", m1_ack, 0);
        @(negedge clk);
        check_eq("rd_ack_pulse", m0_ack, 0);
        check_eq("rd_data_hold", m0_dat_r, 32'h1234_5678);

        // m1 write
        m1_addr = 32'h0000_0100; m1_we = 4'hF; m1_dat_w = 32'hCAFE_F00D; s_delay = 2;
        pulse(1'b0, 1'b1);
        check_eq("wr_s_stb", s_stb, 1);
        check_eq("wr_s_addr", s_addr, 32'h0000_0100);
        check_eq("wr_s_dat_w", s_dat_w, 32'hCAFE_F00D);
        check_eq("wr_s_we", s_we, 32'hF);
        check_eq("wr_grant", grant, 1);
        @(negedge clk);
        check_eq("wr_stb_pulse", s_stb, 0);
        check_eq("wr_addr_hold", s_addr, 32'h0000_0100);
        wait_ack(1'b1, 10, got);
        check_eq("wr_m1_ack", got, 1);
        check_eq("wr_m0_ack", m0_ack, 0);
        @(negedge clk);
        check_eq("wr_we_clr", s_we, 0);

        // Simultaneous requests, four rounds
        s_delay = 1;
        for (int r = 0; r < 4; r++) begin
            pulse(1'b1, 1'b1);
            collect(2, 30);
            check_eq("rr_count", q0.size(), 2);
            check_eq("rr_first", (q0.size() > 0) ? q0[0] : -1, 0);
            check_eq("rr_second", (q0.size() > 1) ? q0[1] : -1, 1);
            check_eq("fp_first", (qp.size() > 0) ? qp[0] : -1, 0);
            check_eq("fp_second", (qp.size() > 1) ? qp[1] : -1, 1);
        end

        // After an m0-only transaction, contention splits the two modes
        pulse(1'b1, 1'b0);
        collect(1, 20);
        check_eq("solo_m0", (q0.size() > 0) ? q0[0] : -1, 0);
        pulse(1'b1, 1'b1);
        collect(2, 30);
        check_eq("rr_turn_m1", (q0.size() > 0) ? q0[0] : -1, 1);
        check_eq("rr_then_m0", (q0.size() > 1) ? q0[1] : -1, 0);
        check_eq("fp_m0_wins", (qp.size() > 0) ? qp[0] : -1, 0);
        check_eq("fp_then_m1", (qp.size() > 1) ? qp[1] : -1, 1);

        // m1 request during m0 WAIT is served right after m0 completes
        s_delay = 4; s_resp = 32'hAAAA_0001;
        m1_addr = 32'h0000_0200; m1_we = 4'h0;
        pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b1);
        wait_ack(1'b0, 10, got);
        check_eq("q_m0_ack", got, 1);
        @(negedge clk);
        check_eq("q_m1_stb", s_stb, 1);
        check_eq("q_m1_grant", grant, 1);
        check_eq("q_m1_addr", s_addr, 32'h0000_0200);
        wait_ack(1'b1, 10, got);
        check_eq("q_m1_ack", got, 1);
        check_eq("q_m1_data", m1_dat_r, 32'hAAAA_0001);

        // Timeout: slave silent, completion in WAIT cycle 9
        @(negedge clk);
        s_auto = 1'b0; s_ack = 1'b0;
        m0_addr = 32'h0000_0300;
        pulse(1'b1, 1'b0);
        early = 0;
        if (m0_ack) early++;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            if (m0_ack || err) early++;
        end
        check_eq("to_early", early, 0);
        @(negedge clk);
        check_eq("to_ack", m0_ack, 1);
        check_eq("to_data", m0_dat_r, 32'hDEAD_BEEF);
        check_eq("to_err", err, 1);
        @(negedge clk);
        check_eq("to_err_pulse", err, 0);
        s_ack = 1'b1; s_dat_r = 32'h5555_5555;
        @(negedge clk);
        s_ack = 1'b0;
        check_eq("late_ack", m0_ack, 0);
        check_eq("late_stb", s_stb, 0);
        check_eq("late_hold", m0_dat_r, 32'hDEAD_BEEF);

        // Reset during WAIT abandons the transaction
        s_auto = 1'b1; s_delay = 6; s_resp = 32'h7777_0000;
        pulse(1'b1, 1'b0);
        check_eq("rw_stb", s_stb, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("rw_outs", {s_addr | s_dat_w | m0_dat_r | m1_dat_r}, 32'h0);
        check_eq("rw_ctl", {s_we, s_stb, m0_ack, m1_ack, err, grant}, 32'h0);
        early = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (m0_ack || m1_ack) early++;
        end
        check_eq("rw_no_ack", early, 0);
        s_delay = 1; s_resp = 32'h0BAD_F00D;
        pulse(1'b1, 1'b0);
        wait_ack(1'b0, 10, got);
        check_eq("rw_new_ack", got, 1);
        check_eq("rw_new_data", m0_dat_r, 32'h0BAD_F00D);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
